// File: rtl/mult_pkg.sv
// Shared types and sizing for the shift-and-add multiplier.
package mult_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int unsigned DEFAULT_WIDTH = 32;

   // Iteration counter width: enough bits to hold WIDTH-1, never less than one.
   function automatic int unsigned cnt_width(input int unsigned w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

   localparam int unsigned CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/mult_step.sv
// One shift-and-add iteration: conditional accumulate, then shift multiplicand left and multiplier right.
module mult_step
   import mult_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic [2*WIDTH-1:0] acc,
   input  logic [2*WIDTH-1:0] mcand,
   input  logic [WIDTH-1:0]   mplier,
   output logic [2*WIDTH-1:0] acc_next_c,
   output logic [2*WIDTH-1:0] mcand_next_c,
   output logic [WIDTH-1:0]   mplier_next_c
);

   always_comb begin
      acc_next_c    = acc;
      mcand_next_c  = mcand << 1;
      mplier_next_c = mplier >> 1;
      // Partial products of a zero-extended operand never overflow 2*WIDTH bits.
      if (mplier[0]) begin
         acc_next_c = acc + mcand;
      end
   end

endmodule

// File: rtl/multiplication_circuit.sv
// Sequential unsigned multiplier with busy/done handshake, one partial product per clock.
// Optional MULT_EARLY_EXIT_EN ends the run once no multiplier bits remain.
module multiplication_circuit
   import mult_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] p
);

   localparam int unsigned PW = 2 * WIDTH;
   localparam int unsigned CW = cnt_width(WIDTH);

   state_t            state;
   logic [PW-1:0]     acc;
   logic [PW-1:0]     mcand;
   logic [WIDTH-1:0]  mplier;
   logic [CW-1:0]     count;

   logic [PW-1:0]     acc_nx_c;
   logic [PW-1:0]     mcand_nx_c;
   logic [WIDTH-1:0]  mplier_nx_c;
   logic              last_c;

   mult_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .acc           (acc),
      .mcand         (mcand),
      .mplier        (mplier),
      .acc_next_c    (acc_nx_c),
      .mcand_next_c  (mcand_nx_c),
      .mplier_next_c (mplier_nx_c)
   );

`ifdef MULT_EARLY_EXIT_EN
   assign last_c = (count == '0) || (mplier_nx_c == '0);
`else
   assign last_c = (count == '0);
`endif

   // FSM, iteration registers and registered handshake outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state  <= IDLE;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         count  <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         p      <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  mcand  <= PW'(a);
                  mplier <= b;
                  acc    <= '0;
                  count  <= CW'(WIDTH - 1);
                  busy   <= 1'b1;
                  state  <= RUN;
               end
            end
            RUN: begin
               acc    <= acc_nx_c;
               mcand  <= mcand_nx_c;
               mplier <= mplier_nx_c;
               count  <= count - CW'(1);
               if (last_c) begin
                  p     <= acc_nx_c;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multiplication_circuit.sv
// Self-checking bench for multiplication_circuit against an arithmetic reference model.
module tb_multiplication_circuit;

   localparam int unsigned W     = 32;
   localparam int          LIMIT = 200;

   logic           clock = 1'b0;
   logic           reset;
   logic           start;
   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic           busy;
   logic           done;
   logic [2*W-1:0] p;

   int checks   = 0;
   int failures = 0;

   always #5 clock = ~clock;

   multiplication_circuit #(
      .WIDTH (W)
   ) dut (
      .clock (clock),
      .reset (reset),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .p     (p)
   );

   // Reference: product is plain unsigned multiplication.
   function automatic logic [2*W-1:0] exp_prod(input logic [W-1:0] av, input logic [W-1:0] bv);
      return (2*W)'(av) * (2*W)'(bv);
   endfunction

   // Reference: clock cycles from the accepting edge until done is visible.
   function automatic int exp_cycles(input logic [W-1:0] bv);
`ifdef MULT_EARLY_EXIT_EN
      int hi;
      hi = -1;
      for (int i = 0; i < int'(W); i++) if (bv[i]) hi = i;
      return (hi + 1 < 1) ? 1 : hi + 1;
`else
      return (bv === 'x) ? -1 : int'(W);
`endif
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Advance until done is seen or the budget runs out; n = cycles waited.
   task automatic wait_done(output int n);
      n = 0;
      while (done !== 1'b1 && n < LIMIT) begin
         tick();
         n++;
      end
   endtask

   task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv);
      a     = av;
      b     = bv;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b1;
      a     = 32'd5;
      b     = 32'd5;
      tick();
      tick();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || p !== '0) begin
         failures++;
         $display("FAIL reset_state busy=%b done=%b p=%h required 0/0/0", busy, done, p);
      end
      reset = 1'b0;
      start = 1'b0;
      tick();
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_no_start busy=%b required 0", busy);
      end
   endtask

   task automatic test_basic();
      int n;
      launch(32'd6, 32'd7);
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         failures++;
         $display("FAIL basic_busy busy=%b done=%b required 1/0", busy, done);
      end
      a = 32'hDEAD_BEEF;
      b = 32'h1234_5678;
      wait_done(n);
      checks++;
      if (n !== exp_cycles(32'd7)) begin
         failures++;
         $display("FAIL basic_latency cycles=%0d required %0d", n, exp_cycles(32'd7));
      end
      checks++;
      if (p !== 64'd42 || busy !== 1'b0) begin
         failures++;
         $display("FAIL basic_product p=%0d busy=%b required 42/0", p, busy);
      end
      tick();
      checks++;
      if (done !== 1'b0 || p !== 64'd42) begin
         failures++;
         $display("FAIL basic_hold done=%b p=%0d required 0/42", done, p);
      end
   endtask

   task automatic test_corners();
      logic [W-1:0] ta [4];
      logic [W-1:0] tb [4];
      int n;
      ta = '{32'hFFFF_FFFF, 32'h1234_5678, 32'd2,         32'd10};
      tb = '{32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 32'd3};
      for (int i = 0; i < 4; i++) begin
         launch(ta[i], tb[i]);
         wait_done(n);
         checks++;
         if (n !== exp_cycles(tb[i]) || p !== exp_prod(ta[i], tb[i])) begin
            failures++;
            $display("FAIL corner_%0d cycles=%0d p=%h required %0d/%h",
                     i, n, p, exp_cycles(tb[i]), exp_prod(ta[i], tb[i]));
         end
      end
      checks++;
      if (exp_prod(ta[0], tb[0]) !== 64'hFFFF_FFFE_0000_0001 || p !== 64'd30) begin
         failures++;
         $display("FAIL corner_values p=%h required 1e", p);
      end
      tick();
   endtask

   task automatic test_random();
      logic [W-1:0] av;
      logic [W-1:0] bv;
      int n;
      for (int i = 0; i < 10; i++) begin
         av = $urandom;
         bv = $urandom >> $urandom_range(0, 31);
         launch(av, bv);
         wait_done(n);
         checks++;
         if (n !== exp_cycles(bv) || p !== exp_prod(av, bv)) begin
            failures++;
            $display("FAIL random_%0d a=%h b=%h cycles=%0d p=%h required %0d/%h",
                     i, av, bv, n, p, exp_cycles(bv), exp_prod(av, bv));
         end
      end
      tick();
   endtask

   task automatic test_ignore_busy();
      int n;
      int pulse_at;
      pulse_at = (exp_cycles(32'd5) > 9) ? 9 : 0;
      launch(32'd3, 32'd5);
      n = 0;
      while (done !== 1'b1 && n < LIMIT) begin
         if (n == pulse_at) begin
            start = 1'b1;
            a     = 32'd9;
            b     = 32'd9;
         end else begin
            start = 1'b0;
         end
         tick();
         n++;
      end
      start = 1'b0;
      checks++;
      if (n !== exp_cycles(32'd5) || p !== 64'd15) begin
         failures++;
         $display("FAIL ignore_busy cycles=%0d p=%0d required %0d/15", n, p, exp_cycles(32'd5));
      end
      // Restart from the done cycle itself.
      launch(32'd9, 32'd9);
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || p !== 64'd15) begin
         failures++;
         $display("FAIL restart_in_done busy=%b done=%b p=%0d required 1/0/15", busy, done, p);
      end
      wait_done(n);
      checks++;
      if (n !== exp_cycles(32'd9) || p !== 64'd81) begin
         failures++;
         $display("FAIL restart_result cycles=%0d p=%0d required %0d/81", n, p, exp_cycles(32'd9));
      end
      tick();
   endtask

   task automatic test_reset_mid_run();
      int n;
      int pulses;
      launch(32'd100, 32'd200);
      for (int i = 0; i < 15; i++) tick();
      reset = 1'b1;
      start = 1'b1;
      tick();
      reset = 1'b0;
      start = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || p !== '0) begin
         failures++;
         $display("FAIL reset_abort busy=%b done=%b p=%h required 0/0/0", busy, done, p);
      end
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         if (done === 1'b1 || busy === 1'b1) pulses++;
         tick();
      end
      checks++;
      if (pulses !== 0) begin
         failures++;
         $display("FAIL reset_no_done active_cycles=%0d required 0", pulses);
      end
      launch(32'd100, 32'd200);
      wait_done(n);
      checks++;
      if (n !== exp_cycles(32'd200) || p !== 64'd20000) begin
         failures++;
         $display("FAIL reset_fresh cycles=%0d p=%0d required %0d/20000", n, p, exp_cycles(32'd200));
      end
      tick();
   endtask

   task automatic test_back_to_back();
      int n;
      a     = 32'd2;
      b     = 32'd3;
      start = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         wait_done(n);
         if (i > 0) n++;
         checks++;
         if (n !== exp_cycles(32'd3) + (i > 0 ? 1 : 0) || p !== 64'd6) begin
            failures++;
            $display("FAIL back_to_back_%0d period=%0d p=%0d required %0d/6",
                     i, n, p, exp_cycles(32'd3) + (i > 0 ? 1 : 0));
         end
         tick();
      end
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         failures++;
         $display("FAIL back_to_back_no_gap busy=%b done=%b required 1/0", busy, done);
      end
      wait_done(n);
      tick();
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      tick();
      test_reset();
      test_basic();
      test_corners();
      test_random();
      test_ignore_busy();
      test_reset_mid_run();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
